// File: rtl/wdt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_ctrl_pkg
//  Brief    : Shared constants for the watchdog register controller.
//  Revision : 1.0
// ============================================================================
package wdt_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EXEC   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_FEED   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_LIVE   = 3'd1;
    localparam logic [2:0] IDX_TOCNT  = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_KEY    = 3'd4;

    localparam int CTRL_WDEN     = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_AUTO_DIS = 2;

    localparam int STAT_STICKY  = 0;
    localparam int STAT_CNT_CLR = 1;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_WTO     = 16;

    localparam logic [31:0] KEY_VAL_DEFAULT = 32'h5A5A_5A5A;

endpackage
`default_nettype wire

// File: rtl/wdt_ctrl_status.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_ctrl_status
//  Brief    : WTO edge detect, sticky flag, saturating event counter and
//             auto-disable request.
//  Revision : 1.0
// ============================================================================
module wdt_ctrl_status #(
    parameter int CNT_W = 8
) (
    input  logic             clk2,
    input  logic             rstn2,
    input  logic             i_wto,
    input  logic             i_auto_dis,
    input  logic             i_clr_sticky,
    input  logic             i_clr_cnt,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_count,
    output logic             o_auto_dis_req
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             wto_prev_q, wto_prev_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_rise;

    always_comb begin
        w_rise     = i_wto & ~wto_prev_q;
        wto_prev_d = i_wto;

        // A new timeout always beats a software clear in the same cycle.
        sticky_d = sticky_q;
        if (i_clr_sticky) sticky_d = 1'b0;
        if (w_rise)       sticky_d = 1'b1;

        count_d = count_q;
        if (w_rise) begin
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
        end else if (i_clr_cnt) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) begin
            wto_prev_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            wto_prev_q <= wto_prev_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign o_sticky       = sticky_q;
    assign o_count        = count_q;
    assign o_auto_dis_req = w_rise & i_auto_dis;

endmodule
`default_nettype wire

// File: rtl/wdt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wdt_ctrl
//  Brief    : Watchdog register controller; sequences WDEN/WDLIVE/WTOCNT and
//             captures WTO events. Define WDT_CTRL_LOCK_EN for key locking.
//  Revision : 1.0
// ============================================================================
module wdt_ctrl
    import wdt_ctrl_pkg::*;
#(
    parameter int          CNT_W   = 8,
    parameter logic [31:0] KEY_VAL = KEY_VAL_DEFAULT
) (
    input  logic        clk2,
    input  logic        rstn2,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        WTO,
    output logic        wto_irq
);

    logic [2:0]       state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      tocnt_q, tocnt_d;
    logic             op_tocnt_q, op_tocnt_d;
    logic             op_live_q, op_live_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             w_hs;
    logic             w_sticky;
    logic [CNT_W-1:0] w_count;
    logic             w_auto_dis_req;
    logic             w_clr_sticky;
    logic             w_clr_cnt;
    logic             w_unlocked;
    logic [31:0]      w_status_rd;

`ifdef WDT_CTRL_LOCK_EN
    logic             unlock_q, unlock_d;
    assign w_unlocked = unlock_q;
`else
    logic             w_unused_key;
    assign w_unlocked   = 1'b1;
    assign w_unused_key = ^KEY_VAL;
`endif

    assign w_hs = cmd_valid & cmd_ready_q;

    always_comb begin
        w_status_rd                        = '0;
        w_status_rd[STAT_STICKY]           = w_sticky;
        w_status_rd[STAT_CNT_LSB +: CNT_W] = w_count;
        w_status_rd[STAT_WTO]              = WTO;
    end

    // Register side effects land on the handshake edge so they are visible in EXEC.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        tocnt_d      = tocnt_q;
        op_tocnt_d   = op_tocnt_q;
        op_live_d    = op_live_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        w_clr_sticky = 1'b0;
        w_clr_cnt    = 1'b0;
`ifdef WDT_CTRL_LOCK_EN
        unlock_d     = unlock_q;
`endif

        if (w_auto_dis_req) ctrl_d[CTRL_WDEN] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    state_d    = ST_EXEC;
                    op_tocnt_d = 1'b0;
                    op_live_d  = 1'b0;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    case (cmd_addr)
                        IDX_CTRL: begin
                            if (!cmd_write) begin
                                rdata_d = {29'd0, ctrl_q};
                            end else if (w_unlocked) begin
                                ctrl_d = cmd_wdata[2:0];
`ifdef WDT_CTRL_LOCK_EN
                                unlock_d = 1'b0;
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        IDX_LIVE: begin
                            op_live_d = cmd_write;
                        end
                        IDX_TOCNT: begin
                            if (!cmd_write) begin
                                rdata_d = tocnt_q;
                            end else if (w_unlocked) begin
                                tocnt_d    = cmd_wdata;
                                op_tocnt_d = 1'b1;
`ifdef WDT_CTRL_LOCK_EN
                                unlock_d   = 1'b0;
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        IDX_STATUS: begin
                            if (cmd_write) begin
                                w_clr_sticky = cmd_wdata[STAT_STICKY];
                                w_clr_cnt    = cmd_wdata[STAT_CNT_CLR];
                            end else begin
                                rdata_d = w_status_rd;
                            end
                        end
`ifdef WDT_CTRL_LOCK_EN
                        IDX_KEY: begin
                            if (cmd_write) unlock_d = (cmd_wdata == KEY_VAL);
                            else           rdata_d  = {31'd0, unlock_q};
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_EXEC: begin
                if (op_live_q) begin
                    if (ctrl_q[CTRL_WDEN]) begin
                        state_d = ST_FEED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end else if (op_tocnt_q && ctrl_q[CTRL_WDEN]) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_SETTLE: state_d = ST_FEED;
            ST_FEED:   state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            ctrl_q      <= '0;
            tocnt_q     <= '0;
            op_tocnt_q  <= 1'b0;
            op_live_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            ctrl_q      <= ctrl_d;
            tocnt_q     <= tocnt_d;
            op_tocnt_q  <= op_tocnt_d;
            op_live_q   <= op_live_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

`ifdef WDT_CTRL_LOCK_EN
    always_ff @(posedge clk2 or negedge rstn2) begin
        if (!rstn2) unlock_q <= 1'b0;
        else        unlock_q <= unlock_d;
    end
`endif

    wdt_ctrl_status #(
        .CNT_W (CNT_W)
    ) u_status (
        .clk2           (clk2),
        .rstn2          (rstn2),
        .i_wto          (WTO),
        .i_auto_dis     (ctrl_q[CTRL_AUTO_DIS]),
        .i_clr_sticky   (w_clr_sticky),
        .i_clr_cnt      (w_clr_cnt),
        .o_sticky       (w_sticky),
        .o_count        (w_count),
        .o_auto_dis_req (w_auto_dis_req)
    );

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign WDEN      = ctrl_q[CTRL_WDEN];
    assign WDLIVE    = (state_q == ST_FEED);
    assign WTOCNT    = tocnt_q;
    assign wto_irq   = w_sticky & ctrl_q[CTRL_IRQ_EN];

endmodule
`default_nettype wire

// File: doc/wdt_ctrl.md
# wdt_ctrl

Register-level controller for the watchdog timer in the `clk2` domain. It accepts read/write commands from the read side of the CDC AFIFO and owns the watchdog configuration registers. It drives the timer's `WDEN`, `WDLIVE` and `WTOCNT` inputs with correct sequencing, so that a reload-value change takes effect on the live counter. It also captures timeout events from `WTO` into sticky status, a saturating event counter and an interrupt line.

## Interface
Parameters:
- `CNT_W`, default 8: width of the saturating timeout-event counter (1..8).
- `KEY_VAL`, default `32'h5A5A_5A5A`: unlock key, used only when the lock feature is compiled in.

Ports (one clock; reset is asynchronous and active-low):
- `clk2` in 1: controller and watchdog clock.
- `rstn2` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 3: register word index.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_err` out 1: command rejected or unmapped.
- `WDEN` out 1: watchdog enable, level.
- `WDLIVE` out 1: feed pulse, exactly one cycle.
- `WTOCNT` out 32: reload value.
- `WTO` in 1: watchdog timeout.
- `wto_irq` out 1: `STATUS.sticky` & `CTRL.irq_en`.

## Operation
Register map (word index):
- 0 CTRL: bit0 = `WDEN`, bit1 = irq_en, bit2 = auto_dis.
- 1 LIVE: write-only feed; reads return 0.
- 2 TOCNT: reload value.
- 3 STATUS: bit0 = sticky timeout (write 1 clears); bit1 written 1 clears the counter; bits[8+CNT_W-1:8] = event count; bit16 = live `WTO` (read-only).
- 4 KEY: see Configuration.
- 5–7: unmapped. Reads return 0 with `rsp_err`=1; writes are ignored with `rsp_err`=1.

FSM states: IDLE, EXEC, SETTLE, FEED, RESP.
- IDLE: `cmd_ready`=1. On handshake, latch the command and go to EXEC.
- EXEC performs the register action:
  - TOCNT write while `WDEN`=1: go to SETTLE.
  - LIVE write: `WDEN`=1 goes to FEED; `WDEN`=0 drops the write, sets `rsp_err`=1 and goes to RESP.
  - All other commands: go to RESP.
- SETTLE (1 cycle): lets the watchdog sample the new `WTOCNT`, then go to FEED.
- FEED (1 cycle): `WDLIVE`=1, then go to RESP.
- RESP: `rsp_valid`=1, outputs held stable until `rsp_ready`, then go to IDLE.

Timeout capture runs every cycle, independent of the FSM:
- A `WTO` rising edge (registered previous value) sets sticky and increments the counter.
- The counter saturates at 2^CNT_W−1.
- If auto_dis=1, the rising edge clears `CTRL.WDEN` on the next edge.
- A STATUS write-1-clear in the same cycle as a rising edge: set wins, and the counter increments rather than clears.
- A CTRL write in the same cycle as an auto_dis clear: the CTRL write wins.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, then 1 in IDLE.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `WDEN`=0, `WDLIVE`=0, `WTOCNT`=0, `wto_irq`=0.
  - CTRL=0, sticky=0, count=0, FSM=IDLE.
- Handshake in cycle T. Register effect is visible from cycle T+1 (EXEC), and `rsp_valid` is asserted in cycle T+2 for CTRL, STATUS, KEY, reads and LIVE rejects.
- LIVE accepted: `WDLIVE` high in cycle T+2, `rsp_valid` in T+3.
- TOCNT with `WDEN`=1: `WTOCNT` new from T+1, `WDLIVE` high in T+3, `rsp_valid` in T+4. With `WDEN`=0: no pulse, response in T+2.
- One command in flight at a time: `cmd_ready`=0 from T+1 until the cycle after the response handshake.
- `wto_irq` follows sticky one cycle after the `WTO` rise.
- Asynchronous reset mid-command: the command is discarded and no response is issued.

## Configuration
- `WDT_CTRL_LOCK_EN` defined:
  - CTRL and TOCNT writes require a prior KEY write equal to `KEY_VAL`. Otherwise the write is ignored with `rsp_err`=1.
  - The lock re-arms after any accepted CTRL/TOCNT write.
  - A KEY write with a wrong value re-arms the lock.
  - A KEY read returns 1 if unlocked.
  - LIVE and STATUS writes are never locked.
- `WDT_CTRL_LOCK_EN` undefined: index 4 is unmapped, and CTRL/TOCNT writes are always accepted.

## Structure
- `wdt_ctrl_pkg` holds:
  - the FSM state enum;
  - register index constants;
  - CTRL and STATUS bit positions;
  - the default `KEY_VAL`.
- One sub-module, `wdt_ctrl_status`, holds:
  - the `WTO` edge detect;
  - the sticky bit;
  - the saturating counter;
  - the clear/set priority;
  - the auto_dis request output.

## Test plan
- After reset, write TOCNT=10, then CTRL=1 → `WTOCNT`=10 and `WDEN`=1; no `WDLIVE` pulse; each response has `rsp_err`=0.
- With `WDEN`=1, write TOCNT=20 at T → `WDLIVE` high only in T+3; `rsp_valid` in T+4; the watchdog counter reloads to 20.
- LIVE write with `WDEN`=0 → no `WDLIVE`, `rsp_err`=1. With `WDEN`=1 → single-cycle pulse at T+2.
- Force 3 `WTO` rises with irq_en=1 → count=3, sticky=1, `wto_irq`=1. Write STATUS=1 in the same cycle as a 4th rise → sticky stays 1 and count=4.
- auto_dis=1 and a `WTO` rise → `WDEN` drops next cycle; a STATUS read shows live `WTO`=0 after the watchdog deasserts.
- With `WDT_CTRL_LOCK_EN` defined:
  - CTRL write without a key → `rsp_err`=1 and `WDEN` unchanged.
  - KEY=`32'h5A5A_5A5A` then CTRL=1 → `WDEN`=1.
  - A second CTRL write after that → rejected.
